fifo_burst_reader: RTL



---
 rtl/fifo_burst_reader.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - drains a synchronous FIFO in fixed-length bursts onto a valid/ready stream
// Partial residues are flushed as a short burst once the FIFO has sat non-empty for TIMEOUT idle cycles.
module fifo_burst_reader #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int USED_W    = 5,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_fifo_data,
  input  logic              i_fifo_empty,
  input  logic [USED_W-1:0] i_fifo_used_slot,
  output logic              o_fifo_rd_en,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_last,
  output logic              o_busy,
  output logic              o_flush
);
  localparam int                TMR_W       = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0]  TMR_MAX     = TMR_W'(TIMEOUT - 1);
  localparam logic [USED_W-1:0] BURST_WORDS = USED_W'(BURST_LEN);
  localparam logic [USED_W-1:0] DEPTH_WORDS = USED_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, BURST, FLUSH} state_t;

  state_t             state_q, state_d;
  logic [USED_W-1:0]  remaining_q, remaining_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               flush_q, flush_d;
  logic               inflight_q, inflight_d;
  logic               inflight_last_q, inflight_last_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]  buf0_q, buf0_d, buf1_q, buf1_d;
  logic               last0_q, last0_d, last1_q, last1_d;
  logic               pop;
  logic [2:0]         occ;

  assign o_valid = (cnt_q != 2'd0);
  assign o_data  = buf0_q;
  assign o_last  = o_valid & last0_q;
  assign o_busy  = (state_q != IDLE);
  assign o_flush = flush_q;
  assign pop     = o_valid & i_ready;

  // Words already owed to the 2-entry buffer after this cycle's pop; never request a third.
  assign occ = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};

  assign o_fifo_rd_en = (state_q != IDLE) && (remaining_q != '0) && !i_fifo_empty && (occ < 3'd2);

  assign inflight_d      = o_fifo_rd_en;
  assign inflight_last_d = o_fifo_rd_en && (remaining_q == USED_W'(1));

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    flush_d     = flush_q;
    timer_d     = '0;
    case (state_q)
      IDLE: begin
        if (i_fifo_used_slot >= BURST_WORDS) begin
          state_d     = BURST;
          remaining_d = BURST_WORDS;
        end else if (!i_fifo_empty && timer_q == TMR_MAX) begin
          state_d     = FLUSH;
          remaining_d = (i_fifo_used_slot > DEPTH_WORDS) ? DEPTH_WORDS : i_fifo_used_slot;
          flush_d     = 1'b1;
        end else if (!i_fifo_empty) begin
          timer_d = (timer_q == TMR_MAX) ? TMR_MAX : timer_q + 1'b1;
        end
      end
      BURST, FLUSH: begin
        remaining_d = remaining_q - USED_W'(o_fifo_rd_en);
        if (pop && last0_q) begin
          state_d = IDLE;
          flush_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    last0_d = last0_q;
    last1_d = last1_q;
    cnt_d   = cnt_q;
    if (pop) begin
      buf0_d  = buf1_q;
      last0_d = last1_q;
      cnt_d   = cnt_q - 2'd1;
    end
    if (inflight_q) begin
      if (cnt_d == 2'd0) begin
        buf0_d  = i_fifo_data;
        last0_d = inflight_last_q;
      end else begin
        buf1_d  = i_fifo_data;
        last1_d = inflight_last_q;
      end
      cnt_d = cnt_d + 2'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q         <= IDLE;
      remaining_q     <= '0;
      timer_q         <= '0;
      flush_q         <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      cnt_q           <= 2'd0;
      buf0_q          <= '0;
      buf1_q          <= '0;
      last0_q         <= 1'b0;
      last1_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      remaining_q     <= remaining_d;
      timer_q         <= timer_d;
      flush_q         <= flush_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      cnt_q           <= cnt_d;
      buf0_q          <= buf0_d;
      buf1_q          <= buf1_d;
      last0_q         <= last0_d;
      last1_q         <= last1_d;
    end
  end
endmodule
